// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I-style ALU, iterative shifter; `define ALU_MUL_EN adds a shift-add MUL (op 1001)
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int RD_W       = 6,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_function,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_c,
  input  logic [RD_W-1:0] i_rd,
  input  logic            i_wr,
  output logic            o_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_val,
  output logic [RD_W-1:0] o_rd,
  output logic            o_wr
);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [SW:0] STEP = SHIFT_STEP[SW:0];
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL = 2'd3;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
`endif
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] val_q, val_d, res, sra_v;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wr_q, wr_d, left_q, left_d, arith_q, arith_d;
  logic [SW:0]     rem_q, rem_d, amt;
  logic [SW-1:0]   sh_n;
  logic            accept, is_shift, slt, sltu;
  assign sh_n     = i_c[SW-1:0];
  assign is_shift = i_function inside {4'b0001, 4'b0101, 4'b1101};
  assign o_ready  = !i_rst && !i_flush && (state_q == S_IDLE || (state_q == S_DONE && i_out_ready));
  assign accept   = i_valid && o_ready;
  assign slt      = $signed(i_b) < $signed(i_c);
  assign sltu     = i_b < i_c;
  // Shift ops carry the unshifted operand; a zero amount completes with it directly.
  assign res = i_function == 4'b0000 ? i_b + i_c :
               i_function == 4'b1000 ? i_b - i_c :
               i_function == 4'b0010 ? {{(XLEN-1){1'b0}}, slt} :
               i_function == 4'b0011 ? {{(XLEN-1){1'b0}}, sltu} :
               i_function == 4'b0100 ? i_b ^ i_c :
               i_function == 4'b0110 ? i_b | i_c :
               i_function == 4'b0111 ? i_b & i_c :
               is_shift              ? i_b : '0;
  assign amt   = rem_q < STEP ? rem_q : STEP;
  assign sra_v = $signed(val_q) >>> amt;
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    left_d  = left_q;
    arith_d = arith_q;
    rem_d   = rem_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    if (i_flush) state_d = S_IDLE;
    else if (accept) begin
      rd_d    = i_rd;
      wr_d    = i_wr;
      val_d   = res;
      left_d  = !i_function[2];
      arith_d = i_function[3];
      rem_d   = {1'b0, sh_n};
      state_d = is_shift && sh_n != '0 ? S_SHIFT : S_DONE;
`ifdef ALU_MUL_EN
      if (i_function == 4'b1001) begin
        val_d    = '0;
        mcand_d  = i_b;
        mplier_d = i_c;
        rem_d    = XLEN[SW:0];
        state_d  = S_MUL;
      end
`endif
    end else if (state_q == S_SHIFT) begin
      val_d   = left_q ? val_q << amt : arith_q ? sra_v : val_q >> amt;
      rem_d   = rem_q - amt;
      state_d = rem_d == '0 ? S_DONE : S_SHIFT;
    end
`ifdef ALU_MUL_EN
    else if (state_q == S_MUL) begin
      val_d    = mplier_q[0] ? val_q + mcand_q : val_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      rem_d    = rem_q - (SW+1)'(1);
      state_d  = rem_d == '0 ? S_DONE : S_MUL;
    end
`endif
    else if (state_q == S_DONE && i_out_ready) state_d = S_IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
      rem_q   <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      left_q  <= left_d;
      arith_q <= arith_d;
      rem_q   <= rem_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end
  assign o_valid = state_q == S_DONE;
  assign o_val   = val_q;
  assign o_rd    = rd_q;
  assign o_wr    = wr_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq with SHIFT_STEP=1 (dut) and SHIFT_STEP=4 (dut4)
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst, flush, valid, out_ready, wr;
  logic [3:0]  fn;
  logic [31:0] b, c;
  logic [5:0]  rd;
  logic        ready, ovalid, owr, ready4, ovalid4, owr4;
  logic [31:0] oval, oval4;
  logic [5:0]  ord, ord4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_seq #(.XLEN(32), .RD_W(6), .SHIFT_STEP(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready),
    .i_function(fn), .i_b(b), .i_c(c), .i_rd(rd), .i_wr(wr), .o_valid(ovalid),
    .i_out_ready(out_ready), .o_val(oval), .o_rd(ord), .o_wr(owr));
  alu_seq #(.XLEN(32), .RD_W(6), .SHIFT_STEP(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready4),
    .i_function(fn), .i_b(b), .i_c(c), .i_rd(rd), .i_wr(wr), .o_valid(ovalid4),
    .i_out_ready(out_ready), .o_val(oval4), .o_rd(ord4), .o_wr(owr4));
  logic [3:0]  tf [10] = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h0, 4'hF, 4'h1};
  logic [31:0] tbv [10] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F00000,
                            32'hF0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'd5, 32'h1234};
  logic [31:0] tcv [10] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'hFF00FF00,
                            32'h0F, 32'hFF00FF00, 32'd2, 32'd7, 32'h20};
  logic [31:0] tev [10] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h0FF0FF00,
                            32'hFF, 32'hF000F000, 32'd1, 32'd0, 32'h1234};
  task automatic issue(input logic [3:0] f, input logic [31:0] bb, input logic [31:0] cc,
                       input logic [5:0] r, input logic w);
    fn = f; b = bb; c = cc; rd = r; wr = w; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; fn = 4'h0; b = 32'hDEADBEEF; c = 32'hFFFFFFFF; rd = 6'h3F; wr = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = 1'b0; out_ready = 1'b1;
    fn = 4'h0; b = '0; c = '0; rd = '0; wr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ovalid); end
    checks++; if (oval !== 32'h0) begin errors++; $display("FAIL reset_val: got %h expected 0", oval); end
    checks++; if (ord !== 6'h0 || owr !== 1'b0) begin errors++; $display("FAIL reset_rd_wr: got %h/%b expected 0/0", ord, owr); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
    @(negedge clk);
  endtask
  task automatic test_alu_back_to_back();
    for (int i = 0; i < 10; i++) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready); end
      fn = tf[i]; b = tbv[i]; c = tcv[i]; rd = 6'(i + 1); wr = i[0]; valid = 1'b1;
      @(negedge clk);
      checks++; if (ovalid !== 1'b1 || oval !== tev[i]) begin errors++; $display("FAIL b2b_val[%0d]: got %b/%h expected 1/%h", i, ovalid, oval, tev[i]); end
      checks++; if (ord !== 6'(i + 1) || owr !== i[0]) begin errors++; $display("FAIL b2b_rd_wr[%0d]: got %h/%b expected %h/%b", i, ord, owr, 6'(i + 1), i[0]); end
    end
    valid = 1'b0;
    @(negedge clk);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", ovalid); end
  endtask
  task automatic run_multi(input logic [3:0] f, input logic [31:0] bb, input logic [31:0] cc,
                           input logic [31:0] exp, input int lat1, input int lat4, input string nm);
    int k1 = 0;
    int k4 = 0;
    int busy_bad = 0;
    logic [31:0] v1 = '0;
    logic [31:0] v4 = '0;
    issue(f, bb, cc, 6'd9, 1'b1);
    for (int k = 1; k <= 40 && (k1 == 0 || k4 == 0); k++) begin
      if (ovalid && k1 == 0) begin k1 = k; v1 = oval; end
      if (k1 == 0 && ready) busy_bad++;
      if (ovalid4 && k4 == 0) begin k4 = k; v4 = oval4; end
      @(negedge clk);
    end
    checks++; if (k1 != lat1) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, k1, lat1); end
    checks++; if (v1 !== exp) begin errors++; $display("FAIL %s value: got %h expected %h", nm, v1, exp); end
    checks++; if (k4 != lat4) begin errors++; $display("FAIL %s latency_step4: got %0d expected %0d", nm, k4, lat4); end
    checks++; if (v4 !== exp) begin errors++; $display("FAIL %s value_step4: got %h expected %h", nm, v4, exp); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s busy_ready: got %0d ready cycles expected 0", nm, busy_bad); end
  endtask
  task automatic test_shift();
    run_multi(4'b1101, 32'h80000000, 32'd4,  32'hF8000000, 5,  2, "sra4");
    run_multi(4'b0001, 32'h00000001, 32'h25, 32'h00000020, 6,  3, "sll_0x25");
    run_multi(4'b0101, 32'h000000F0, 32'd4,  32'h0000000F, 5,  2, "srl4");
    run_multi(4'b1101, 32'h40000000, 32'd3,  32'h08000000, 4,  2, "sra_pos3");
    run_multi(4'b1101, 32'h80000001, 32'd31, 32'hFFFFFFFF, 32, 9, "sra31");
    run_multi(4'b0101, 32'h80000000, 32'd31, 32'h00000001, 32, 9, "srl31");
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(4'b0000, 32'd10, 32'd20, 6'd7, 1'b1);
    checks++; if (ovalid !== 1'b1 || oval !== 32'd30) begin errors++; $display("FAIL bp_first: got %b/%h expected 1/1e", ovalid, oval); end
    fn = 4'b1000; b = 32'd100; c = 32'd1; rd = 6'd8; wr = 1'b0; valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, ready); end
      checks++; if (ovalid !== 1'b1 || oval !== 32'd30 || ord !== 6'd7 || owr !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%b expected 1/1e/07/1", k, ovalid, oval, ord, owr); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ovalid !== 1'b1 || oval !== 32'd99 || ord !== 6'd8 || owr !== 1'b0) begin
      errors++; $display("FAIL bp_next: got %b/%h/%h/%b expected 1/63/08/0", ovalid, oval, ord, owr); end
    @(negedge clk);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", ovalid); end
  endtask
  task automatic test_flush();
    int seen = 0;
    issue(4'b0101, 32'hF0, 32'd8, 6'd2, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ovalid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_shift: got %0d valid cycles expected 0", seen); end
    flush = 1'b1; fn = 4'b0000; b = 32'd1; c = 32'd1; valid = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", ready); end
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b expected 0", ovalid); end
    out_ready = 1'b0;
    issue(4'b0000, 32'd4, 32'd4, 6'd1, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", ovalid); end
    issue(4'b0000, 32'd1, 32'd2, 6'd4, 1'b1);
    checks++; if (ovalid !== 1'b1 || oval !== 32'd3 || ord !== 6'd4) begin
      errors++; $display("FAIL flush_after_add: got %b/%h/%h expected 1/3/04", ovalid, oval, ord); end
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    int seen = 0;
    issue(4'b0101, 32'hF0, 32'd8, 6'd5, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (oval !== 32'h0 || ord !== 6'h0 || owr !== 1'b0) begin
      errors++; $display("FAIL arst_shift_outputs: got %h/%h/%b expected 0/0/0", oval, ord, owr); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b expected 0", ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_idle_ready: got %b expected 1", ready); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ovalid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL arst_no_result: got %0d valid cycles expected 0", seen); end
    out_ready = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 6'd3, 1'b1);
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL arst_done_pre: got %b expected 1", ovalid); end
    #3 rst = 1'b1;
    #1;
    checks++; if (ovalid !== 1'b0 || oval !== 32'h0) begin errors++; $display("FAIL arst_done: got %b/%h expected 0/0", ovalid, oval); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask
`ifdef ALU_MUL_EN
  task automatic test_mul();
    run_multi(4'b1001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, "mul");
  endtask
`else
  task automatic test_mul();
    run_multi(4'b1001, 32'd7, 32'hFFFFFFFD, 32'h0, 1, 1, "mul_disabled");
  endtask
`endif
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_alu_back_to_back();
    test_shift();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
